// File: rtl/sha_pkg.sv
// Shared constants and types for the SHA-256 message padder.
// No ports; imported by sha_pad_fmt and sha_pad_blocks.
package sha_pkg;

  localparam int unsigned HDR_W = 640;
  localparam int unsigned BLK_W = 512;

  // First padding word: a single '1' bit right after the message.
  localparam logic [31:0] PAD_WORD     = 32'h8000_0000;
  // Message length in bits, big-endian, in the final 64 bits of block 1.
  localparam logic [63:0] MSG_LEN_BITS = 64'd640;

  // Zero fill between PAD_WORD and the length field in block 1.
  localparam int unsigned ZERO_W = BLK_W - 128 - 32 - 64;

  typedef enum logic [1:0] {
    StIdle,
    StBlk0,
    StBlk1
  } sha_state_e;

  typedef enum logic {
    BlkSel0,
    BlkSel1
  } blk_sel_e;

endpackage

// File: rtl/sha_pad_fmt.sv
// Purely combinational block formatter: maps a 640-bit header plus a block
// select to one 512-bit SHA-256 message block.
//   hdr_i      header (bits [639:608] word 0, bits [31:0] nonce)
//   blk_sel_i  BlkSel0 = raw header head, BlkSel1 = header tail + padding + length
//   blk_o      formatted message block
module sha_pad_fmt
  import sha_pkg::*;
(
  input  logic [HDR_W-1:0] hdr_i,
  input  blk_sel_e         blk_sel_i,
  output logic [BLK_W-1:0] blk_o
);

  always_comb begin
    blk_o = '0;
    unique case (blk_sel_i)
      BlkSel0: blk_o = hdr_i[HDR_W-1:128];
      BlkSel1: blk_o = {hdr_i[127:0], PAD_WORD, {ZERO_W{1'b0}}, MSG_LEN_BITS};
      default: blk_o = '0;
    endcase
  end

endmodule

// File: rtl/sha_pad_blocks.sv
// SHA-256 front end: captures an 80-byte block header and emits its two padded
// 512-bit message blocks, each held on M with en_next high until accepted.
// Optional feature macro: NONCE_SWEEP_EN (block 1 re-emitted NONCE_ITERS times
// with an incrementing nonce; adds the nonce_out port).
//   clk, reset  clock and asynchronous active-high reset
//   hdr_valid   header present on 'header' (only sampled while idle)
//   header      640-bit block header
//   hdr_ready   high while idle and out of reset
//   M           current message block
//   en_next     M valid
//   blk_ready   downstream accepts M this cycle when en_next is high
//   last        M is block 1
//   busy        high in every state except idle
//   nonce_out   nonce carried in the current block 1 (NONCE_SWEEP_EN only)
module sha_pad_blocks
  import sha_pkg::*;
#(
  parameter int unsigned NONCE_ITERS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hdr_valid,
  input  logic [HDR_W-1:0] header,
  output logic             hdr_ready,
  output logic [BLK_W-1:0] M,
  output logic             en_next,
  input  logic             blk_ready,
  output logic             last,
  output logic             busy
`ifdef NONCE_SWEEP_EN
  ,
  output logic [31:0]      nonce_out
`endif
);

  sha_state_e       state_q, state_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [BLK_W-1:0] m_q, m_d;
  logic             en_q, en_d;
  logic             last_q, last_d;

  // load: a new block is presented on M at the coming edge.
  logic             load;
  blk_sel_e         sel_d;
  logic [BLK_W-1:0] fmt_blk;

`ifdef NONCE_SWEEP_EN
  localparam int unsigned CntW = (NONCE_ITERS > 1) ? $clog2(NONCE_ITERS) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Formats from the next-state header so M updates on the same edge as the
  // capture / nonce increment, with no bubble between blocks.
  sha_pad_fmt u_fmt (
    .hdr_i     (hdr_d),
    .blk_sel_i (sel_d),
    .blk_o     (fmt_blk)
  );

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    load    = 1'b0;
    sel_d   = BlkSel0;
`ifdef NONCE_SWEEP_EN
    cnt_d   = cnt_q;
`endif
    // In StBlk0/StBlk1 en_next is always high, so blk_ready is already qualified.
    unique case (state_q)
      StIdle: begin
        if (hdr_valid) begin
          hdr_d   = header;
          state_d = StBlk0;
          load    = 1'b1;
          sel_d   = BlkSel0;
        end
      end
      StBlk0: begin
        if (blk_ready) begin
          state_d = StBlk1;
          load    = 1'b1;
          sel_d   = BlkSel1;
`ifdef NONCE_SWEEP_EN
          cnt_d   = '0;
`endif
        end
      end
      StBlk1: begin
        if (blk_ready) begin
`ifdef NONCE_SWEEP_EN
          if (cnt_q == CntW'(NONCE_ITERS - 1)) begin
            state_d = StIdle;
          end else begin
            cnt_d       = cnt_q + 1'b1;
            hdr_d[31:0] = hdr_q[31:0] + 32'd1;
            load        = 1'b1;
            sel_d       = BlkSel1;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_d    = m_q;
    en_d   = en_q;
    last_d = last_q;
    if (load) begin
      m_d    = fmt_blk;
      en_d   = 1'b1;
      last_d = (sel_d == BlkSel1);
    end else if (state_d == StIdle) begin
      en_d   = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hdr_q   <= '0;
      m_q     <= '0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
`ifdef NONCE_SWEEP_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      m_q     <= m_d;
      en_q    <= en_d;
      last_q  <= last_d;
`ifdef NONCE_SWEEP_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign M         = m_q;
  assign en_next   = en_q;
  assign last      = last_q;
  assign busy      = (state_q != StIdle);
  assign hdr_ready = (state_q == StIdle) && !reset;
`ifdef NONCE_SWEEP_EN
  assign nonce_out = hdr_q[31:0];
`endif

endmodule

// File: tb/tb_sha_pad_blocks.sv
// Self-checking bench for sha_pad_blocks: scoreboard of expected blocks pushed
// when a header is driven, popped and compared on every accepted block.
module tb_sha_pad_blocks;

`ifdef NONCE_SWEEP_EN
  localparam int unsigned ITERS = 4;
`else
  localparam int unsigned ITERS = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         hdr_valid;
  logic [639:0] header;
  logic         hdr_ready;
  logic [511:0] M;
  logic         en_next;
  logic         blk_ready;
  logic         last;
  logic         busy;
`ifdef NONCE_SWEEP_EN
  logic [31:0]  nonce_out;
`endif

  always #5 clk = ~clk;

  sha_pad_blocks #(
    .NONCE_ITERS (ITERS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hdr_valid (hdr_valid),
    .header    (header),
    .hdr_ready (hdr_ready),
    .M         (M),
    .en_next   (en_next),
    .blk_ready (blk_ready),
    .last      (last),
    .busy      (busy)
`ifdef NONCE_SWEEP_EN
    ,
    .nonce_out (nonce_out)
`endif
  );

  typedef struct {
    logic [511:0] m;
    logic         last;
    logic [31:0]  nonce;
  } exp_t;

  exp_t sb_q[$];
  logic last_log[$];
  int   checks   = 0;
  int   failures = 0;
  int   accepted = 0;

  task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Expected blocks for one header: block 0 once, then ITERS block-1 emissions.
  function automatic void push_hdr(input logic [639:0] h);
    exp_t         e;
    logic [639:0] hh;
    e.m     = h[639:128];
    e.last  = 1'b0;
    e.nonce = h[31:0];
    sb_q.push_back(e);
    for (int i = 0; i < int'(ITERS); i++) begin
      hh        = h;
      hh[31:0]  = h[31:0] + 32'(i);
      e.m       = {hh[127:0], 32'h8000_0000, 288'h0, 64'd640};
      e.last    = 1'b1;
      e.nonce   = hh[31:0];
      sb_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && en_next && blk_ready) begin
      exp_t e;
      accepted++;
      last_log.push_back(last);
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_blk", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_m", M, e.m);
        check_eq("sb_last", last, e.last);
`ifdef NONCE_SWEEP_EN
        check_eq("sb_nonce", nonce_out, e.nonce);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || en_next) && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, {busy, en_next}, 2'b00);
  endtask

  // Single-cycle header pulse; caller ensures the DUT is idle.
  task automatic send_hdr(input logic [639:0] h);
    header    = h;
    hdr_valid = 1'b1;
    push_hdr(h);
    tick();
    hdr_valid = 1'b0;
  endtask

  logic [639:0] ha, hb, hc, hd;
  logic [511:0] m_hold;
  int           n;

  initial begin
    reset     = 1'b1;
    hdr_valid = 1'b0;
    header    = '0;
    blk_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_en", en_next, 1'b0);
    check_eq("rst_m", M, 512'h0);
    check_eq("rst_last", last, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    check_eq("rst_hdr_ready", hdr_ready, 1'b1);

    // Basic frame, blk_ready tied high.
    blk_ready = 1'b1;
    ha = {32'h0200_0000, 576'h0, 32'h1234_5678};
    send_hdr(ha);
    check_eq("basic_c1_en", en_next, 1'b1);
    check_eq("basic_c1_m", M, {32'h0200_0000, 480'h0});
    check_eq("basic_c1_last", last, 1'b0);
    check_eq("basic_c1_busy", busy, 1'b1);
    tick();
    check_eq("basic_c2_m", M, {96'h0, 32'h1234_5678, 32'h8000_0000, 288'h0, 64'h280});
    check_eq("basic_c2_last", last, 1'b1);
`ifndef NONCE_SWEEP_EN
    tick();
    check_eq("basic_c3_en", en_next, 1'b0);
`endif
    wait_idle("basic_idle");

    // Backpressure in BLK0 for 5 cycles.
    blk_ready = 1'b0;
    hb = {32'hdead_beef, 32'h0bad_cafe, 512'h0123_4567_89ab_cdef, 64'h5555_aaaa_5555_aaaa};
    send_hdr(hb);
    m_hold = M;
    check_eq("bp_m0", m_hold, hb[639:128]);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("bp_hold_m%0d", i), M, m_hold);
      check_eq($sformatf("bp_hold_en%0d", i), {en_next, last}, 2'b10);
    end
    blk_ready = 1'b1;
    tick();
    check_eq("bp_blk1_last", {en_next, last}, 2'b11);
    wait_idle("bp_idle");

    // hdr_valid during BLK1 is ignored.
    blk_ready = 1'b0;
    hc = {16{40'h13_57_9b_df_02}};
    send_hdr(hc);
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    m_hold = M;
    header    = ~hc;
    hdr_valid = 1'b1;
    tick();
    hdr_valid = 1'b0;
    tick();
    check_eq("ign_m", M, m_hold);
    check_eq("ign_last", {en_next, last, hdr_ready}, 3'b110);
    blk_ready = 1'b1;
    wait_idle("ign_idle");
    n = accepted;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("ign_idle_en%0d", i), en_next, 1'b0);
    end
    check_eq("ign_idle_nacc", 32'(accepted - n), 32'd0);
    check_eq("ign_sb_empty", 32'(sb_q.size()), 32'd0);

    // Back-to-back headers with hdr_valid held high.
    last_log.delete();
    hc = {32'h1111_1111, 576'h0, 32'hcafe_0001};
    hd = {32'h2222_2222, 576'h0, 32'hcafe_0002};
    header    = hc;
    hdr_valid = 1'b1;
    push_hdr(hc);
    tick();
    check_eq("b2b_cap0", {en_next, last}, 2'b10);
    header = hd;
    push_hdr(hd);
    n = 0;
    while (!hdr_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("b2b_gap_en", {hdr_ready, en_next}, 2'b10);
    tick();
    hdr_valid = 1'b0;
    check_eq("b2b_cap1", {en_next, last}, 2'b10);
    wait_idle("b2b_idle");
    check_eq("b2b_nblk", 32'(last_log.size()), 32'(2 * (1 + ITERS)));
    for (int i = 0; i < last_log.size(); i++) begin
      check_eq($sformatf("b2b_last%0d", i), last_log[i], (i % (1 + ITERS)) != 0);
    end

`ifdef NONCE_SWEEP_EN
    // Nonce sweep across the 32-bit wrap.
    n = accepted;
    blk_ready = 1'b1;
    send_hdr({32'h0200_0000, 576'h0, 32'hffff_fffe});
    wait_idle("sweep_idle");
    check_eq("sweep_nacc", 32'(accepted - n), 32'd5);
`endif

    // Asynchronous reset mid-BLK0.
    blk_ready = 1'b0;
    send_hdr({32'h3333_3333, 576'h0, 32'h0000_0042});
    check_eq("mid_en_pre", en_next, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_en", en_next, 1'b0);
    check_eq("mid_rst_m", M, 512'h0);
    sb_q.delete();
    tick();
    reset = 1'b0;
    tick();
    check_eq("mid_rst_state", {hdr_ready, busy, en_next, last}, 4'b1000);

    check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
